// File: rtl/conv_window_feeder.sv
// Gathers a 3x3 pixel window and its weights, starts the conv engine, and returns its result.
// Optional build macro CONV_FEEDER_RELU_EN clamps negative results to zero.
module conv_window_feeder #(
  parameter int DW      = 16,
  parameter int KN      = 9,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             reuse_w,
  output logic [DW*KN-1:0] im,
  output logic [DW*KN-1:0] iw,
  output logic             conv_ready,
  input  logic [DW-1:0]    om,
  input  logic             conv_valid,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             timeout_err
);

  // state    | meaning
  // LOAD_IM  | accepting pixels into im slots
  // LOAD_IW  | accepting weights into iw slots
  // START    | one-cycle start strobe to the engine
  // WAIT     | waiting for a rising conv_valid, watchdog running
  // OUT      | holding the result until downstream accepts it
  typedef enum logic [2:0] {
    S_LOAD_IM,
    S_LOAD_IW,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  localparam int CW = $clog2(KN + 1);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          reuse_q;
  logic          w_loaded;
  logic          prev_valid;
  logic [WW-1:0] wd;
  logic [DW-1:0] im_q [KN];
  logic [DW-1:0] iw_q [KN];

  logic          accept;
  logic          last;
  logic          reuse_eff;
  logic          rise;
  logic          wd_expire;
  logic [DW-1:0] result;

  for (genvar k = 0; k < KN; k++) begin : g_pack
    assign im[DW*k +: DW] = im_q[k];
    assign iw[DW*k +: DW] = iw_q[k];
  end

  assign accept     = in_valid & in_ready;
  assign last       = (cnt == CW'(KN - 1));
  assign reuse_eff  = (cnt == '0) ? reuse_w : reuse_q;
  assign rise       = conv_valid & ~prev_valid;
  // Watchdog counts down from TIMEOUT; the TIMEOUT-th WAIT cycle aborts.
  assign wd_expire  = (TIMEOUT != 0) && (wd == WW'(1));
  assign conv_ready = (state == S_START);
  assign busy       = !((state == S_LOAD_IM) && (cnt == '0));

`ifdef CONV_FEEDER_RELU_EN
  assign result = om[DW-1] ? '0 : om;
`else
  assign result = om;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD_IM: if (accept && last) state_nxt = (reuse_eff && w_loaded) ? S_START : S_LOAD_IW;
      S_LOAD_IW: if (accept && last) state_nxt = S_START;
      S_START:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (rise)           state_nxt = S_OUT;
        else if (wd_expire) state_nxt = S_LOAD_IM;
      end
      S_OUT:     if (out_valid && out_ready) state_nxt = S_LOAD_IM;
      default:   state_nxt = S_LOAD_IM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LOAD_IM;
      cnt         <= '0;
      reuse_q     <= 1'b0;
      w_loaded    <= 1'b0;
      prev_valid  <= 1'b0;
      wd          <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      timeout_err <= 1'b0;
      for (int k = 0; k < KN; k++) begin
        im_q[k] <= '0;
        iw_q[k] <= '0;
      end
    end else begin
      state       <= state_nxt;
      // Registered so that ready falls the cycle after the final beat.
      in_ready    <= (state_nxt == S_LOAD_IM) || (state_nxt == S_LOAD_IW);
      timeout_err <= 1'b0;
      case (state)
        S_LOAD_IM: begin
          if (accept) begin
            im_q[cnt] <= in_data;
            if (cnt == '0) reuse_q <= reuse_w;
            cnt <= last ? '0 : cnt + CW'(1);
          end
        end
        S_LOAD_IW: begin
          if (accept) begin
            iw_q[cnt] <= in_data;
            if (last) begin
              cnt      <= '0;
              w_loaded <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_START: begin
          wd         <= WW'(TIMEOUT);
          prev_valid <= conv_valid;
        end
        S_WAIT: begin
          prev_valid <= conv_valid;
          if (rise) begin
            out_data  <= result;
            out_valid <= 1'b1;
          end else if (wd_expire) begin
            timeout_err <= 1'b1;
            w_loaded    <= 1'b0;
            cnt         <= '0;
          end else if (wd != '0) begin
            wd <= wd - WW'(1);
          end
        end
        S_OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: window-level model of slots, weight reuse and result path.
module tb_conv_window_feeder;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         reuse_w = 1'b0;
  logic [143:0] im, iw;
  logic         conv_ready;
  logic [15:0]  om = '0;
  logic         conv_valid = 1'b0;
  logic [15:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         timeout_err;

  conv_window_feeder #(.DW(16), .KN(9), .TIMEOUT(1023)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reuse_w(reuse_w), .im(im), .iw(iw), .conv_ready(conv_ready), .om(om),
    .conv_valid(conv_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

`ifdef CONV_FEEDER_RELU_EN
  localparam logic [15:0] EXP_C400 = 16'h0000;
`else
  localparam logic [15:0] EXP_C400 = 16'hC400;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // Window-level model: slot contents, whether weights are resident, pending result.
  logic [15:0] exp_im [9];
  logic [15:0] exp_iw [9];
  logic [15:0] exp_out = '0;
  bit          mw_loaded = 0;
  bit          cmp_en = 0;
  logic [15:0] pix_v [9];
  logic [15:0] wts_v [9];

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [143:0] pack(input bit sel_w);
    logic [143:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[16*k +: 16] = sel_w ? exp_iw[k] : exp_im[k];
    return v;
  endfunction

  function automatic logic [15:0] res_model(input logic [15:0] v);
`ifdef CONV_FEEDER_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("im_model", im, pack(1'b0));
      chk("iw_model", iw, pack(1'b1));
      if (out_valid) chk("out_data_model", {128'h0, out_data}, {128'h0, exp_out});
    end
  end

  task automatic beat(input logic [15:0] d, input bit is_w, input int idx, input bit rw);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_beat", {143'h0, in_ready}, 144'h1);
    in_data = d; in_valid = 1'b1; reuse_w = rw;
    @(posedge clk); #1;
    if (is_w) exp_iw[idx] = d; else exp_im[idx] = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_window(input bit reuse, input int bubble_at, output int beats);
    beats = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == bubble_at && i > 0) begin
        repeat (2) begin
          @(negedge clk);
          chk("bubble_busy", {143'h0, busy}, 144'h1);
          chk("bubble_in_ready", {143'h0, in_ready}, 144'h1);
        end
      end
      beat(pix_v[i], 1'b0, i, (i == 0) ? reuse : ~reuse);
      beats++;
    end
    if (!(reuse && mw_loaded)) begin
      for (int i = 0; i < 9; i++) begin
        beat(wts_v[i], 1'b1, i, ~reuse);
        beats++;
      end
      mw_loaded = 1;
    end
    chk("conv_ready_pulse", {143'h0, conv_ready}, 144'h1);
    chk("in_ready_drop", {143'h0, in_ready}, 144'h0);
  endtask

  // Entered at the START negedge; delay >= 1 so the rise lands in WAIT.
  task automatic finish_op(input logic [15:0] om_v, input logic [15:0] exp_v,
                           input int delay, input int rdelay, input bit sim_in);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      if (d == 0) chk("conv_ready_one_cycle", {143'h0, conv_ready}, 144'h0);
      chk("no_early_out", {143'h0, out_valid}, 144'h0);
    end
    if (conv_valid) begin
      conv_valid = 1'b0;
      @(negedge clk);
      chk("no_out_on_stale_valid", {143'h0, out_valid}, 144'h0);
    end
    conv_valid = 1'b1; om = om_v; exp_out = res_model(om_v);
    @(negedge clk);
    conv_valid = 1'b0; om = 16'h7BFF;
    chk("out_valid_rise", {143'h0, out_valid}, 144'h1);
    chk("out_data_lit", {128'h0, out_data}, {128'h0, exp_v});
    for (int r = 0; r < rdelay; r++) begin
      @(negedge clk);
      chk("out_hold", {143'h0, out_valid}, 144'h1);
    end
    out_ready = 1'b1;
    if (sim_in) begin in_valid = 1'b1; in_data = 16'hDEAD; end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk("out_valid_clear", {143'h0, out_valid}, 144'h0);
    chk("in_ready_after_out", {143'h0, in_ready}, 144'h1);
    chk("idle_not_busy", {143'h0, busy}, 144'h0);
  endtask

  initial begin
    int beats;
    int k;
    for (int i = 0; i < 9; i++) begin exp_im[i] = '0; exp_iw[i] = '0; end

    // Reset state
    #12;
    chk("rst_in_ready", {143'h0, in_ready}, 144'h0);
    chk("rst_conv_ready", {143'h0, conv_ready}, 144'h0);
    chk("rst_out_valid", {143'h0, out_valid}, 144'h0);
    chk("rst_busy", {143'h0, busy}, 144'h0);
    chk("rst_timeout_err", {143'h0, timeout_err}, 144'h0);
    chk("rst_im", im, 144'h0);
    chk("rst_iw", iw, 144'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1;

    // Window A: full load
    for (int i = 0; i < 9; i++) begin pix_v[i] = 16'h3C00; wts_v[i] = 16'h4000; end
    run_window(1'b0, -1, beats);
    chk("a_beats", 144'(beats), 144'd18);
    chk("a_im_lit", im, {9{16'h3C00}});
    chk("a_iw_lit", iw, {9{16'h4000}});
    finish_op(16'h4C80, 16'h4C80, 3, 0, 1'b0);

    // Window B: weight reuse, input offered during output handshake
    for (int i = 0; i < 9; i++) begin pix_v[i] = 16'(i + 1); wts_v[i] = 16'h1111; end
    run_window(1'b1, -1, beats);
    chk("b_beats", 144'(beats), 144'd9);
    chk("b_iw_kept", iw, {9{16'h4000}});
    chk("b_im_slot8", {128'h0, im[143:128]}, {128'h0, 16'h0009});
    finish_op(16'hC400, EXP_C400, 1, 2, 1'b1);

    // Window C: new weights, bubble mid-window, conv_valid already high at START
    for (int i = 0; i < 9; i++) begin pix_v[i] = 16'h2000 + 16'(i); wts_v[i] = 16'h5000 + 16'(i); end
    conv_valid = 1'b1;
    run_window(1'b0, 4, beats);
    chk("c_beats", 144'(beats), 144'd18);
    chk("c_iw_slot0", {128'h0, iw[15:0]}, {128'h0, 16'h5000});
    finish_op(16'h4400, 16'h4400, 3, 1, 1'b0);

    // Window D: reuse then watchdog abort
    for (int i = 0; i < 9; i++) pix_v[i] = 16'h0100 + 16'(i);
    run_window(1'b1, -1, beats);
    chk("d_beats", 144'(beats), 144'd9);
    k = 0;
    while (!timeout_err && k < 1100) begin
      @(negedge clk);
      k++;
      if (k == 1) chk("d_conv_ready_one_cycle", {143'h0, conv_ready}, 144'h0);
      if (k == 1000) chk("d_still_waiting", {143'h0, in_ready}, 144'h0);
    end
    chk("timeout_cycles", 144'(k), 144'd1024);
    chk("timeout_in_ready", {143'h0, in_ready}, 144'h1);
    mw_loaded = 0;
    @(negedge clk);
    chk("timeout_pulse_end", {143'h0, timeout_err}, 144'h0);

    // Window E: reuse requested but weights were dropped by the abort
    for (int i = 0; i < 9; i++) wts_v[i] = 16'h3800 + 16'(i);
    run_window(1'b1, -1, beats);
    chk("e_beats", 144'(beats), 144'd18);
    finish_op(16'h0123, 16'h0123, 2, 0, 1'b0);

    // Reset in the middle of the weight load
    for (int i = 0; i < 9; i++) beat(16'h6000 + 16'(i), 1'b0, i, 1'b0);
    for (int i = 0; i < 4; i++) beat(16'h6100 + 16'(i), 1'b1, i, 1'b0);
    chk("pre_rst_busy", {143'h0, busy}, 144'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int i = 0; i < 9; i++) begin exp_im[i] = '0; exp_iw[i] = '0; end
    mw_loaded = 0;
    #1;
    chk("mid_rst_im", im, 144'h0);
    chk("mid_rst_iw", iw, 144'h0);
    chk("mid_rst_in_ready", {143'h0, in_ready}, 144'h0);
    chk("mid_rst_busy", {143'h0, busy}, 144'h0);
    chk("mid_rst_out_data", {128'h0, out_data}, 144'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Window F: restarts at pixel slot 0 and needs weights again
    for (int i = 0; i < 9; i++) begin pix_v[i] = 16'h0A00 + 16'(i); wts_v[i] = 16'h0B00 + 16'(i); end
    run_window(1'b1, -1, beats);
    chk("f_beats", 144'(beats), 144'd18);
    chk("f_im_slot0", {128'h0, im[15:0]}, {128'h0, 16'h0A00});
    finish_op(16'h4C80, 16'h4C80, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Producer end of the 3x3 convolution engine handshake.
- Collects a stream of 16-bit half-precision words: 9 image pixels, then 9 weights.
- Packs them into the two 144-bit operand buses, starts the engine with a one-cycle start strobe, and waits for the engine's done strobe.
- Returns the 16-bit result on a valid/ready output stream. Sits between the line buffer/DMA read path and the conv engine.

Parameters:
- DW, 16, element width in bits (fp16).
- KN, 9, elements per window (3x3).
- TIMEOUT, 1023, max cycles in WAIT before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  DW  input element (pixel or weight)
- in_valid  in  1  in_data valid
- in_ready  out  1  feeder accepts in_data this cycle
- reuse_w  in  1  sampled at the first pixel of a window; 1 = keep previously loaded weights, skip weight load
- im  out  DW*KN  packed pixels, element k at [DW*k+DW-1 : DW*k]
- iw  out  DW*KN  packed weights, same packing
- conv_ready  out  1  start strobe to engine
- om  in  DW  engine result
- conv_valid  in  1  engine result valid
- out_data  out  DW  result word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- busy  out  1  high in any state other than LOAD_IM with count 0
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, rst_n=0): state LOAD_IM; element counter 0; im=0, iw=0, conv_ready=0, out_valid=0, out_data=0, in_ready=0, busy=0, timeout_err=0; weights-loaded flag cleared; watchdog cleared. Reset mid-operation discards any partial window and any pending result.
- States:
  - LOAD_IM: in_ready=1. Each in_valid&in_ready writes in_data to im slot[cnt], cnt++. reuse_w is latched on the cnt=0 beat. After slot 8: go to LOAD_IW (cnt=0), unless reuse_w is latched and the weights-loaded flag is set, in which case go to START.
  - LOAD_IW: in_ready=1. Fills iw slot[cnt] the same way. After slot 8: set weights-loaded flag, go to START.
  - START: conv_ready=1 for exactly one cycle; in_ready=0; clear watchdog; register prev_valid <= conv_valid. Go to WAIT.
  - WAIT: in_ready=0; im/iw held stable. On a rising edge of conv_valid (conv_valid=1, prev_valid=0): out_data <= om, out_valid <= 1, go to OUT. Watchdog increments every WAIT cycle; when it reaches TIMEOUT (TIMEOUT>0), pulse timeout_err, go to LOAD_IM with cnt=0 and the weights-loaded flag cleared.
  - OUT: hold out_data and out_valid until out_ready. On out_valid&out_ready: out_valid <= 0, go to LOAD_IM.
- Latencies:
  - Last beat accepted at cycle t gives conv_ready=1 at t+1.
  - conv_valid rising at cycle t gives out_valid=1 at t+1.
  - in_ready drops the cycle after the last accepted element.
- conv_valid that is already high at START is not taken as completion; only a 0->1 transition counts. The engine must drop conv_valid between operations.
- in_data bubbles (in_valid=0) stall the counter without state change.
- Simultaneous out_ready and new in_valid in OUT: the input is not accepted that cycle; acceptance starts next cycle in LOAD_IM.
- No fp16 arithmetic in this block; om is passed through as-is unless the optional feature is enabled.

Optional Feature:
- Macro: CONV_FEEDER_RELU_EN.
- With the macro: captured result passes through ReLU. If om[15]=1 (negative, including -0), out_data=16'h0000; otherwise out_data=om. NaN with sign set also becomes 0.
- Without the macro: out_data=om unchanged.

Test Plan:
- Reset then 18 beats (pixels 16'h3C00 x9, weights 16'h4000 x9) -> im=9x3C00, iw=9x4000, conv_ready high exactly 1 cycle, the cycle after beat 18.
- In WAIT, drive conv_valid 0->1 with om=16'h4C80 and out_ready=1 -> out_valid one cycle later with out_data=4C80, cleared after the handshake, then in_ready=1.
- Second window with reuse_w=1 on its first beat -> START after 9 beats, iw unchanged; same with no prior weight load -> weights are still loaded (18 beats).
- Hold conv_valid=0 for TIMEOUT=1023 cycles in WAIT -> timeout_err pulse, return to LOAD_IM, next window requires 18 beats even with reuse_w=1.
- rst_n low mid-LOAD_IW (cnt=4) -> all outputs at reset values immediately; the next window restarts at pixel slot 0.
- With CONV_FEEDER_RELU_EN, om=16'hC400 -> out_data=0000; om=16'h4400 -> out_data=4400. Without the macro, om=16'hC400 -> out_data=C400.
